// File: rtl/sp_ram_arbiter.sv
// sp_ram_arbiter: round-robin arbiter sharing one single-port RAM between NUM_REQ masters.
//
// Each requester uses req/gnt/rvalid. The winner of the current cycle is granted
// combinationally and drives the RAM port. Its response (rvalid plus the shared rdata)
// appears one cycle later.
//
// Ports (requester k occupies slice k of every flattened vector):
//   clk, rstn_i        clock, asynchronous active-low reset
//   req_i, we_i        per-requester request and write strobe
//   addr_i, be_i,      per-requester byte address, byte enables, write data
//   wdata_i
//   gnt_o, rvalid_o    per-requester grant and response valid (one-hot or zero)
//   rdata_o            read data, shared by all requesters
//   ram_*_o            RAM enable, address, write enable, byte enables, write data
//   ram_rdata_i        RAM read data, valid one cycle after enable
module sp_ram_arbiter #(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned ADDR_WIDTH = 15,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                            clk,
    input  logic                            rstn_i,
    input  logic [NUM_REQ-1:0]              req_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   addr_i,
    input  logic [NUM_REQ-1:0]              we_i,
    input  logic [NUM_REQ*DATA_WIDTH/8-1:0] be_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   wdata_i,
    output logic [NUM_REQ-1:0]              gnt_o,
    output logic [NUM_REQ-1:0]              rvalid_o,
    output logic [DATA_WIDTH-1:0]           rdata_o,
    output logic                            ram_en_o,
    output logic [ADDR_WIDTH-1:0]           ram_addr_o,
    output logic                            ram_we_o,
    output logic [DATA_WIDTH/8-1:0]         ram_be_o,
    output logic [DATA_WIDTH-1:0]           ram_wdata_o,
    input  logic [DATA_WIDTH-1:0]           ram_rdata_i
);

    localparam int unsigned BeWidth  = DATA_WIDTH / 8;
    localparam int unsigned PtrWidth = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PtrWidth-1:0] rr_q, rr_d;
    logic [PtrWidth-1:0] winner;
    logic [PtrWidth-1:0] cand;
    logic                found;
    logic [NUM_REQ-1:0]  gnt;
    logic [NUM_REQ-1:0]  rvalid_q;
    int unsigned         slot;

    // Scan requesters starting at the priority pointer; the wrap is explicit so that
    // non-power-of-two NUM_REQ never selects a requester that does not exist.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        slot   = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            slot = 32'(rr_q) + i;
            if (slot >= NUM_REQ) begin
                slot = slot - NUM_REQ;
            end
            cand = PtrWidth'(slot);
            if (!found && req_i[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        gnt = '0;
        if (found) begin
            gnt[winner] = 1'b1;
        end
    end

    // RAM port carries the winner's fields, and is fully zeroed when idle.
    always_comb begin
        ram_en_o    = found;
        ram_addr_o  = '0;
        ram_we_o    = 1'b0;
        ram_be_o    = '0;
        ram_wdata_o = '0;
        if (found) begin
            ram_addr_o  = addr_i[winner*ADDR_WIDTH +: ADDR_WIDTH];
            ram_we_o    = we_i[winner];
            ram_be_o    = be_i[winner*BeWidth +: BeWidth];
            ram_wdata_o = wdata_i[winner*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (found) begin
            rr_d = (winner == PtrWidth'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            rr_q     <= '0;
            rvalid_q <= '0;
        end else begin
            rr_q     <= rr_d;
            rvalid_q <= gnt;
        end
    end

    assign gnt_o    = gnt;
    assign rvalid_o = rvalid_q;
    assign rdata_o  = ram_rdata_i;

endmodule

// File: doc/sp_ram_arbiter.md
# sp_ram_arbiter

Round-robin arbiter that shares one single-port, single-cycle-latency RAM (`sp_ram_wrap`) between `NUM_REQ` bus masters, e.g. core data port and AXI/debug slave. Each requester uses a req/gnt/rvalid protocol. The arbiter multiplexes the winning request onto the RAM port and routes the read response back to the granted requester one cycle later. It sits directly in front of the RAM wrapper in the memory subsystem.

## Interface
Parameters:
- `NUM_REQ`, 2: number of requesters (2..8).
- `ADDR_WIDTH`, 15: byte address width, matching the RAM wrapper.
- `DATA_WIDTH`, 32: data width; byte enables are `DATA_WIDTH/8`.

Ports (vectors are flattened; requester k occupies slice k):
- `clk`  in  1  clock, single domain.
- `rstn_i`  in  1  asynchronous active-low reset.
- `req_i`  in  NUM_REQ  request per requester.
- `addr_i`  in  NUM_REQ*ADDR_WIDTH  byte address.
- `we_i`  in  NUM_REQ  1 = write, 0 = read.
- `be_i`  in  NUM_REQ*DATA_WIDTH/8  byte enables.
- `wdata_i`  in  NUM_REQ*DATA_WIDTH  write data.
- `gnt_o`  out  NUM_REQ  grant, one-hot or zero.
- `rvalid_o`  out  NUM_REQ  response valid, one-hot or zero.
- `rdata_o`  out  DATA_WIDTH  read data, shared by all requesters.
- `ram_en_o`  out  1  RAM enable.
- `ram_addr_o`  out  ADDR_WIDTH  RAM address.
- `ram_we_o`  out  1  RAM write enable.
- `ram_be_o`  out  DATA_WIDTH/8  RAM byte enables.
- `ram_wdata_o`  out  DATA_WIDTH  RAM write data.
- `ram_rdata_i`  in  DATA_WIDTH  RAM read data, valid 1 cycle after enable.

## Operation
- State registers:
  - `rr_q` is the priority pointer, `$clog2(NUM_REQ)` bits.
  - `rvalid_q` is `NUM_REQ` bits, holding the one-hot grant of the previous cycle.
- Arbitration is combinational each cycle:
  - The winner is the first asserted `req_i[k]`, scanning k = `rr_q`, `rr_q`+1, … with wrap modulo `NUM_REQ`.
  - `gnt_o[winner]` = 1; all other grants are 0.
- RAM drive:
  - When any request is present: `ram_en_o`=1, and `ram_addr_o`/`ram_we_o`/`ram_be_o`/`ram_wdata_o` carry the winner's slice.
  - When no request is present: `ram_en_o`=0 and all other RAM outputs are 0.
- Pointer update:
  - On a grant to k, `rr_q` <= (k+1) mod `NUM_REQ`. The wrap is explicit, so the non-power-of-2 case is correct.
  - With no grant, `rr_q` holds.
- Response:
  - `rvalid_q` <= `gnt_o`, so `rvalid_o` = `rvalid_q`.
  - `rvalid_o` asserts for both reads and writes. For writes, `rdata_o` is don't-care.
  - `rdata_o` = `ram_rdata_i`, passed through combinationally.
- Requester rules:
  - A requester holds `req_i` and its fields stable until granted.
  - It may drop `req_i` before grant; no transaction occurs in that case.
  - It may issue a new request in the same cycle as its `rvalid_o` (back-to-back).
- Write-then-read to the same address in consecutive cycles returns the new data. The RAM is write-first per cycle, so the arbiter adds no hazard logic.
- No lock, no QoS, no buffering: throughput is one access per cycle in total.

## Timing
- Reset (async assert, sync deassert by the system) sets `rr_q`=0 and `rvalid_q`=0.
- Outputs during and directly after reset:
  - `rvalid_o`=0.
  - `gnt_o` and the `ram_*` outputs follow the combinational rules with `rr_q`=0.
- Latency:
  - `gnt_o` is asserted in the same cycle as `req_i` when the requester wins.
  - `rvalid_o` and `rdata_o` are valid exactly 1 cycle after the grant.
- Simultaneous requests from all requesters: grants rotate, so each requester is granted at least once every `NUM_REQ` cycles (starvation bound).
- Single requester continuously requesting: granted every cycle, and `rvalid_o` stays high every cycle from the second cycle on.
- Reset asserted while a read is in flight (after grant, before rvalid): `rvalid_q` clears immediately and the response is dropped, with no stale `rvalid_o` after reset release.
- A request at the same time as the previous response to the same requester is legal and is granted subject to normal arbitration.

## Test plan
- Single read: reset, preload `mem[0x10]`=0xDEADBEEF, requester 0 reads 0x10 → `gnt_o`=01 in cycle 0; `rvalid_o`=01 and `rdata_o`=0xDEADBEEF in cycle 1.
- Contention: both requesters request continuously from reset → grants alternate 01,10,01,10…, and `rvalid_o` follows one cycle behind.
- Byte write: requester 1 writes 0x12345678 with `be`=0011 to an address holding 0xFFFFFFFF, then reads it → read returns 0xFFFF5678.
- Write/read back-to-back: requester 0 writes 0xA5A5A5A5, then reads the same address the next cycle → rdata 0xA5A5A5A5, and `rvalid_o` is high on both response cycles.
- Reset mid-flight: grant a read, assert `rstn_i`=0 before the next edge → `rvalid_o`=0 immediately and after release; `rr_q` restarts at 0, so a simultaneous 11 request grants requester 0 first.
- NUM_REQ=3, all requesting for 9 cycles → grant order 0,1,2,0,1,2,0,1,2; with only requesters 0 and 2 requesting → 0,2,0,2.
